spram_responder: RTL

//  Single-port RAM responder for the memory-side end of the wr/addr/data bus driven by test and system initiators.

---
 rtl/spram_pkg.sv | 19 +
 rtl/spram_rsp_fifo.sv | 64 ++++++
 rtl/spram_responder.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/spram_pkg.sv
// Shared types for the single-port RAM responder.
//   state_e : controller state (zero-fill sweep, then request service)
//   rsp_t   : one read-response beat (data plus parity-error flag)
// RSP_DATA_W fixes the width of rsp_t and must match the responder's DATA_W.
package spram_pkg;

  typedef enum logic [0:0] {ST_INIT, ST_RUN} state_e;

  localparam int unsigned RSP_DEPTH  = 2;
  localparam int unsigned RSP_DATA_W = 8;
  localparam int unsigned RSP_PTR_W  = $clog2(RSP_DEPTH);
  localparam int unsigned RSP_CNT_W  = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic [RSP_DATA_W-1:0] rdata;
    logic                  err;
  } rsp_t;

endpackage

// File: rtl/spram_rsp_fifo.sv
// Small first-word-fall-through FIFO holding read-response beats.
// Ports:
//   clk, rst          clock, synchronous active-high reset (empties the FIFO)
//   push, push_data   write one beat (ignored when full unless popping at the same edge)
//   pop               drop the head beat (ignored when empty)
//   head              current head beat, valid whenever empty=0
//   count, full, empty occupancy status
module spram_rsp_fifo
  import spram_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  rsp_t                 push_data,
  input  logic                 pop,
  output rsp_t                 head,
  output logic [RSP_CNT_W-1:0] count,
  output logic                 full,
  output logic                 empty
);

  rsp_t                 mem_q [RSP_DEPTH];
  logic [RSP_PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [RSP_CNT_W-1:0] count_q, count_d;
  logic                 push_en, pop_en;

  function automatic logic [RSP_PTR_W-1:0] ptr_inc(input logic [RSP_PTR_W-1:0] p);
    return (p == RSP_PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == RSP_CNT_W'(RSP_DEPTH));
  assign pop_en  = pop & ~empty;
  // A full FIFO can still take a beat when the head leaves at the same edge.
  assign push_en = push & (~full | pop_en);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_en)  rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/spram_responder.sv
// Single-port RAM responder: zero-fills the array after reset, then serves read/write
// requests on a valid/ready channel and returns read data on a valid/ready response channel.
// Up to two reads may be outstanding (one in the stage register plus FIFO contents).
// Optional feature macro: SPRAM_PARITY_EN adds an even-parity bit per entry and flags
// mismatches on rsp_err; without it rsp_err is always 0.
// Ports:
//   clk, rst                      clock, synchronous active-high reset (restarts zero-fill)
//   req_valid/req_ready           request handshake
//   req_wr, req_addr, req_wdata   request command, address, write data
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata, rsp_err            response data and parity-error flag
//   init_done                     high once the zero-fill sweep has completed
module spram_responder
  import spram_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = RSP_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

`ifdef SPRAM_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    cnt_q;
  logic [MEM_W-1:0]     mem [DEPTH];
  logic                 inflight_q;
  rsp_t                 stage_q;
  rsp_t                 fifo_head;
  logic [RSP_CNT_W-1:0] fifo_count;
  logic                 fifo_full, fifo_empty, fifo_push;
  logic [RSP_CNT_W:0]   occ_after_pop;
  logic                 rsp_pop, req_acc, rd_acc;
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_addr;
  logic [MEM_W-1:0]     mem_wdata;

  function automatic logic [MEM_W-1:0] mem_encode(input logic [DATA_W-1:0] d);
`ifdef SPRAM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  function automatic rsp_t mem_decode(input logic [MEM_W-1:0] w);
    rsp_t r;
    r.rdata = w[DATA_W-1:0];
`ifdef SPRAM_PARITY_EN
    r.err = ^w;  // even parity over data plus stored bit must be 0
`else
    r.err = 1'b0;
`endif
    return r;
  endfunction

  // Controller: sweep every address once, then stay in service until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (cnt_q == '1) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign init_done = (state_q == ST_RUN);

  // Occupancy seen by the next read: a beat leaving this edge frees its slot,
  // which keeps back-to-back reads flowing at one per cycle while rsp_ready=1.
  assign rsp_pop       = rsp_valid & rsp_ready;
  assign occ_after_pop = (RSP_CNT_W + 1)'(fifo_count) + (RSP_CNT_W + 1)'(inflight_q)
                       - (RSP_CNT_W + 1)'(rsp_pop);
  assign req_ready     = (state_q == ST_RUN)
                       & (req_wr | (occ_after_pop < (RSP_CNT_W + 1)'(RSP_DEPTH)));
  assign req_acc       = req_valid & req_ready;
  assign rd_acc        = req_acc & ~req_wr;

  // Single write port shared between the zero-fill sweep and request writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = req_addr;
    mem_wdata = mem_encode(req_wdata);
    if (state_q == ST_INIT) begin
      mem_we    = 1'b1;
      mem_addr  = cnt_q;
      mem_wdata = mem_encode('0);
    end else if (req_acc && req_wr) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // Read stage: array sampled at acceptance, beat moves to the FIFO one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rd_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_acc) stage_q <= mem_decode(mem[req_addr]);
  end

  assign fifo_push = inflight_q & (~fifo_full | rsp_pop);

  spram_rsp_fifo u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (stage_q),
    .pop       (rsp_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rsp_valid = ~fifo_empty;
  assign rsp_rdata = rsp_valid ? fifo_head.rdata : '0;
  assign rsp_err   = rsp_valid & fifo_head.err;

endmodule
